// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode and FSM state encodings.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_CLR = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_SL  = 4'd5,
    OP_SR  = 4'd6,
    OP_SET = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_ADC = 4'd10,
    OP_SBC = 4'd11,
    OP_MUL = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath for alu_mc: one-bit-per-cycle shifter and, when
// ALU_MUL_EN is defined, a shift-add multiplier over a 2*WIDTH accumulator.
module alu_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mul_i,
  input  logic             left_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o,
  output logic             hi_nz_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d, work_nx;
  logic             left_q, left_d;

  assign work_nx = left_q ? (work_q << 1) : (work_q >> 1);
  // last_o flags the edge on which the final step lands, so the caller can
  // capture res_o (the post-step value) on that same edge.
  assign last_o  = step_i && (cnt_q == CW'(1));

  always_comb begin
    cnt_d  = cnt_q;
    work_d = work_q;
    left_d = left_q;
    if (start_i) begin
`ifdef ALU_MUL_EN
      cnt_d = mul_i ? CW'(WIDTH) : rs_i[CW-1:0];
`else
      cnt_d = rs_i[CW-1:0];
`endif
      work_d = rt_i;
      left_d = left_i;
    end else if (step_i) begin
      cnt_d  = cnt_q - CW'(1);
      work_d = work_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      work_q <= '0;
      left_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      work_q <= work_d;
      left_q <= left_d;
    end
  end

`ifdef ALU_MUL_EN
  logic                 mul_q, mul_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_nx;
  logic [WIDTH:0]       acc_sum;

  // Multiplier sits in the low half; add multiplicand into the high half
  // when the current LSB is set, then shift the whole accumulator right.
  always_comb begin
    acc_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_nx  = {acc_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    mul_d   = mul_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    if (start_i) begin
      mul_d   = mul_i;
      mcand_d = rs_i;
      acc_d   = {{WIDTH{1'b0}}, rt_i};
    end else if (step_i) begin
      acc_d = acc_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      mul_q   <= mul_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign res_o   = mul_q ? acc_nx[WIDTH-1:0] : work_nx;
  assign hi_nz_o = |acc_nx[2*WIDTH-1:WIDTH];
`else
  logic [WIDTH-CW:0] unused_bits;
  assign unused_bits = {mul_i, rs_i[WIDTH-1:CW]};
  assign res_o       = work_nx;
  assign hi_nz_o     = 1'b0;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle parametrised ALU with valid/ready accept and done pulse.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise op 12 is a NOP.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             z_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             z_q, z_d;
  logic             done_q, done_d;

  logic             accept;
  logic             big_shift;
  logic             complete;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic             iter_start, iter_mul, iter_step, iter_last, iter_hi_nz;
  logic [WIDTH-1:0] iter_res;

  assign ready_o   = (state_q == IDLE) && !rst_i;
  assign accept    = valid_i && ready_o;
  // WIDTH is a power of two, so any set bit at or above log2(WIDTH) means rs >= WIDTH.
  assign big_shift = |rs_i[WIDTH-1:CW-1];
  assign iter_step = (state_q == SHIFT) || (state_q == MUL);

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (iter_start),
    .mul_i   (iter_mul),
    .left_i  (op_i == OP_SL),
    .step_i  (iter_step),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .last_o  (iter_last),
    .res_o   (iter_res),
    .hi_nz_o (iter_hi_nz)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    carry_d    = carry_q;
    z_d        = z_q;
    done_d     = 1'b0;
    complete   = 1'b0;
    op_res     = '0;
    op_carry   = carry_q;
    iter_start = 1'b0;
    iter_mul   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          complete = 1'b1;
          case (op_i)
            OP_CLR: op_carry = 1'b0;
            OP_ADD: {op_carry, op_res} = {1'b0, rs_i} + {1'b0, rt_i};
            OP_SUB: {op_carry, op_res} = {1'b0, rs_i} - {1'b0, rt_i};
            OP_AND: op_res = rs_i & rt_i;
            OP_OR:  op_res = rs_i | rt_i;
            OP_SL, OP_SR: begin
              if (rs_i == '0) begin
                op_res = rt_i;
              end else if (!big_shift) begin
                complete   = 1'b0;
                iter_start = 1'b1;
                state_d    = SHIFT;
              end
            end
            OP_SET: op_res = rs_i;
            OP_INC: {op_carry, op_res} = {1'b0, rs_i} + ONE_W;
            OP_DEC: {op_carry, op_res} = {1'b0, rs_i} - ONE_W;
            OP_ADC: {op_carry, op_res} = {1'b0, rs_i} + {1'b0, rt_i}
                                       + {{WIDTH{1'b0}}, carry_q};
            OP_SBC: {op_carry, op_res} = {1'b0, rs_i} - {1'b0, rt_i}
                                       - {{WIDTH{1'b0}}, carry_q};
`ifdef ALU_MUL_EN
            OP_MUL: begin
              complete   = 1'b0;
              iter_start = 1'b1;
              iter_mul   = 1'b1;
              state_d    = MUL;
            end
`endif
            default: op_res = '0;
          endcase
        end
      end
      SHIFT: begin
        if (iter_last) begin
          complete = 1'b1;
          op_res   = iter_res;
          state_d  = IDLE;
        end
      end
      MUL: begin
        if (iter_last) begin
          complete = 1'b1;
          op_res   = iter_res;
          op_carry = iter_hi_nz;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (complete) begin
      result_d = op_res;
      carry_d  = op_carry;
      z_d      = (op_res == '0);
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign z_o      = z_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus randomized ops
// against an arithmetic reference model. Honours ALU_MUL_EN like the RTL.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [3:0]   op;
  logic [W-1:0] rs, rt;
  logic         ready_o, carry_o, z_o, done_o;
  logic [W-1:0] result_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_carry;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid),
    .ready_o  (ready_o),
    .op_i     (op),
    .rs_i     (rs),
    .rt_i     (rt),
    .result_o (result_o),
    .carry_o  (carry_o),
    .z_o      (z_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain integer arithmetic; lat = edges after accept until done is set.
  function automatic void model_op(input logic [3:0] o, input logic [W-1:0] a, b,
                                   input logic cin, output logic [W-1:0] r,
                                   output logic c, output int lat);
    longint x = longint'(a);
    longint y = longint'(b);
    longint m = longint'(1) << W;
    longint s = 0;
    c   = cin;
    lat = 0;
    case (o)
      4'd0:  c = 1'b0;
      4'd1:  begin s = x + y; c = (s >= m); end
      4'd2:  begin s = x - y; c = (x < y); end
      4'd3:  s = longint'(a & b);
      4'd4:  s = longint'(a | b);
      4'd5:  if (x >= W) s = 0; else begin s = y << x; lat = int'(x); end
      4'd6:  if (x >= W) s = 0; else begin s = y >> x; lat = int'(x); end
      4'd7:  s = x;
      4'd8:  begin s = x + 1; c = (s >= m); end
      4'd9:  begin s = x - 1; c = (x == 0); end
      4'd10: begin s = x + y + longint'(cin); c = (s >= m); end
      4'd11: begin s = x - y - longint'(cin); c = (x < y + longint'(cin)); end
`ifdef ALU_MUL_EN
      4'd12: begin s = x * y; c = (s >= m); lat = W; end
`endif
      default: s = 0;
    endcase
    r = W'(s & (m - 1));
  endfunction

  // Issues one op starting at a negedge and waits (bounded) for done_o.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, b,
                        output logic [W-1:0] r, output logic c, z,
                        output int edges, output int rdy_low, output logic rdy_done);
    op = o; rs = a; rt = b; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    edges = 0;
    rdy_low = 0;
    @(negedge clk);
    while (!done_o && edges <= 200) begin
      if (!ready_o) rdy_low++;
      edges++;
      @(negedge clk);
    end
    r = result_o; c = carry_o; z = z_o; rdy_done = ready_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; op = '0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({result_o, carry_o, z_o, done_o} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got r=%h c=%b z=%b d=%b want all zero",
               result_o, carry_o, z_o, done_o);
    end
    n_tests++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b want 0", ready_o);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %b want 1", ready_o);
    end
    model_carry = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [3:0]   ops [5] = '{OP_ADD, OP_ADC, OP_SUB, OP_SUB, OP_SBC};
    logic [W-1:0] av  [5] = '{8'hF0, 8'h01, 8'h05, 8'h03, 8'h10};
    logic [W-1:0] bv  [5] = '{8'h20, 8'h01, 8'h05, 8'h05, 8'h00};
    logic [W-1:0] er  [5] = '{8'h10, 8'h03, 8'h00, 8'hFE, 8'h0F};
    logic         ec  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         ez  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] r;
    logic c, z, rd;
    int e, rl;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], r, c, z, e, rl, rd);
      n_tests++;
      if (r !== er[i] || c !== ec[i] || z !== ez[i] || e !== 0) begin
        n_fail++;
        $display("[TB] FAIL arith[%0d]: got r=%h c=%b z=%b lat=%0d want r=%h c=%b z=%b lat=0",
                 i, r, c, z, e, er[i], ec[i], ez[i]);
      end
      model_carry = ec[i];
    end
  endtask

  task automatic test_shift();
    logic [3:0]   ops [5] = '{OP_ADD, OP_SL, OP_SR, OP_SR, OP_SL};
    logic [W-1:0] av  [5] = '{8'hFF, 8'h03, 8'h09, 8'h07, 8'h00};
    logic [W-1:0] bv  [5] = '{8'h01, 8'h81, 8'hFF, 8'h80, 8'h5A};
    logic [W-1:0] er  [5] = '{8'h00, 8'h08, 8'h00, 8'h01, 8'h5A};
    logic         ez  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int           el  [5] = '{0, 3, 0, 7, 0};
    logic [W-1:0] r;
    logic c, z, rd;
    int e, rl;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], r, c, z, e, rl, rd);
      n_tests++;
      if (r !== er[i] || c !== 1'b1 || z !== ez[i] || e !== el[i]) begin
        n_fail++;
        $display("[TB] FAIL shift[%0d]: got r=%h c=%b z=%b lat=%0d want r=%h c=1 z=%b lat=%0d",
                 i, r, c, z, e, er[i], ez[i], el[i]);
      end
      n_tests++;
      if (rl !== el[i] || rd !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL shift_ready[%0d]: got low=%0d at_done=%b want low=%0d at_done=1",
                 i, rl, rd, el[i]);
      end
    end
    model_carry = 1'b1;
  endtask

  task automatic test_mul();
    logic [W-1:0] r, exp_r;
    logic c, z, rd, exp_c, exp_z;
    int e, rl, exp_lat;
    run_op(OP_CLR, 8'h00, 8'h00, r, c, z, e, rl, rd);
    n_tests++;
    if (r !== 8'h00 || c !== 1'b0 || z !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clr: got r=%h c=%b z=%b want r=00 c=0 z=1", r, c, z);
    end
`ifdef ALU_MUL_EN
    exp_r = 8'h10; exp_c = 1'b1; exp_z = 1'b0; exp_lat = 8;
`else
    exp_r = 8'h00; exp_c = 1'b0; exp_z = 1'b1; exp_lat = 0;
`endif
    op = OP_MUL; rs = 8'h10; rt = 8'h11; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    e = 0;
    @(negedge clk);
    while (!done_o && e <= 200) begin
      if (e == 2) begin
        valid = 1'b1; op = OP_ADD; rs = 8'h01; rt = 8'h01;
      end else begin
        valid = 1'b0;
      end
      e++;
      @(negedge clk);
    end
    valid = 1'b0;
    n_tests++;
    if (result_o !== exp_r || carry_o !== exp_c || z_o !== exp_z || e !== exp_lat) begin
      n_fail++;
      $display("[TB] FAIL mul: got r=%h c=%b z=%b lat=%0d want r=%h c=%b z=%b lat=%0d",
               result_o, carry_o, z_o, e, exp_r, exp_c, exp_z, exp_lat);
    end
    @(negedge clk);
    n_tests++;
    if (done_o !== 1'b0 || result_o !== exp_r) begin
      n_fail++;
      $display("[TB] FAIL mul_busy_ignored: got done=%b r=%h want done=0 r=%h",
               done_o, result_o, exp_r);
    end
    model_carry = exp_c;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r;
    logic c, z, rd;
    int e, rl, done_seen;
    run_op(OP_ADD, 8'hFF, 8'h01, r, c, z, e, rl, rd);
`ifdef ALU_MUL_EN
    op = OP_MUL; rs = 8'hFF; rt = 8'hFF;
`else
    op = OP_SL; rs = 8'h07; rt = 8'hFF;
`endif
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midop_ready_in_reset: got %b want 0", ready_o);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (result_o !== '0 || carry_o !== 1'b0 || z_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midop_after_reset: got r=%h c=%b z=%b d=%b rdy=%b want 00 0 0 0 1",
               result_o, carry_o, z_o, done_o, ready_o);
    end
    repeat (12) begin
      @(negedge clk);
      if (done_o) done_seen++;
    end
    n_tests++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL midop_no_done: got %0d done pulses want 0", done_seen);
    end
    model_carry = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [3] = '{OP_ADD, OP_AND, OP_OR};
    logic [W-1:0] a, b, er;
    logic ec;
    int lat;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      n_tests++;
      if (ready_o !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready[%0d]: got %b want 1", i, ready_o);
      end
      op = ops[i]; rs = a; rt = b; valid = 1'b1;
      model_op(ops[i], a, b, model_carry, er, ec, lat);
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b1 || result_o !== er || carry_o !== ec || z_o !== (er == '0)) begin
        n_fail++;
        $display("[TB] FAIL b2b[%0d]: got d=%b r=%h c=%b z=%b want d=1 r=%h c=%b z=%b",
                 i, done_o, result_o, carry_o, z_o, er, ec, (er == '0));
      end
      model_carry = ec;
    end
    valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_done_drop: got %b want 0", done_o);
    end
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] a, b, r, er;
    logic c, z, rd, ec;
    int e, rl, lat;
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      a = W'($urandom);
      b = W'($urandom);
      if ((o == OP_SL || o == OP_SR) && $urandom_range(0, 3) != 0)
        a = W'($urandom_range(0, W + 2));
      model_op(o, a, b, model_carry, er, ec, lat);
      run_op(o, a, b, r, c, z, e, rl, rd);
      n_tests++;
      if (r !== er || c !== ec || z !== (er == '0)) begin
        n_fail++;
        $display("[TB] FAIL rand[%0d] op=%0d rs=%h rt=%h: got r=%h c=%b z=%b want r=%h c=%b z=%b",
                 i, o, a, b, r, c, z, er, ec, (er == '0));
      end
      n_tests++;
      if (e !== lat || rl !== lat || rd !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rand_timing[%0d] op=%0d: got lat=%0d low=%0d rdy=%b want lat=%0d low=%0d rdy=1",
                 i, o, e, rl, rd, lat, lat);
      end
      model_carry = ec;
      @(negedge clk);
      n_tests++;
      if (done_o !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rand_pulse[%0d]: got done=%b want 0", i, done_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_mul();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
